// File: rtl/bg_mux.sv
// Background colour selector: 8:1 colour-code mux with a registered copy and a
// background-index change pulse. Define BG_MUX_BLANK_EN to add the 'blank' input.
module bg_mux #(
    parameter int COLOR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
`ifdef BG_MUX_BLANK_EN
    input  logic               blank,
`endif
    input  logic [COLOR_W-1:0] bg0_color,
    input  logic [COLOR_W-1:0] bg1_color,
    input  logic [COLOR_W-1:0] bg2_color,
    input  logic [COLOR_W-1:0] bg3_color,
    input  logic [COLOR_W-1:0] bg4_color,
    input  logic [COLOR_W-1:0] bg5_color,
    input  logic [COLOR_W-1:0] bg6_color,
    input  logic [COLOR_W-1:0] bg7_color,
    input  logic [2:0]         bg,
    output logic [COLOR_W-1:0] color,
    output logic [COLOR_W-1:0] color_q,
    output logic               bg_changed
);

    logic [COLOR_W-1:0] sel_color;
    logic [COLOR_W-1:0] color_reg_d, color_reg_q;
    logic [2:0]         bg_last_d, bg_last_q;
    logic               bg_changed_d, bg_changed_q;

    // Every 3-bit index maps to a source, so no illegal index exists.
    always_comb begin
        sel_color = bg0_color;
        unique case (bg)
            3'd0: sel_color = bg0_color;
            3'd1: sel_color = bg1_color;
            3'd2: sel_color = bg2_color;
            3'd3: sel_color = bg3_color;
            3'd4: sel_color = bg4_color;
            3'd5: sel_color = bg5_color;
            3'd6: sel_color = bg6_color;
            3'd7: sel_color = bg7_color;
        endcase
    end

`ifdef BG_MUX_BLANK_EN
    assign color = blank ? '0 : sel_color;
`else
    assign color = sel_color;
`endif

    always_comb begin
        color_reg_d  = color;
        bg_last_d    = bg;
        bg_changed_d = (bg != bg_last_q);
    end

    // Change detection compares against the index sampled on the previous edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_reg_q  <= '0;
            bg_last_q    <= '0;
            bg_changed_q <= 1'b0;
        end else begin
            color_reg_q  <= color_reg_d;
            bg_last_q    <= bg_last_d;
            bg_changed_q <= bg_changed_d;
        end
    end

    assign color_q    = color_reg_q;
    assign bg_changed = bg_changed_q;

endmodule

// File: tb/tb_bg_mux.sv
// Scoreboard bench for bg_mux: expectations queued when inputs are applied,
// popped and compared after each rising edge.
module tb_bg_mux;
    localparam int W = 3;

    typedef struct packed {
        logic [W-1:0] cq;
        logic         chg;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] cols [8];
    logic [2:0]   bg;
`ifdef BG_MUX_BLANK_EN
    logic         blank;
`endif
    logic [W-1:0] bg0_color, bg1_color, bg2_color, bg3_color;
    logic [W-1:0] bg4_color, bg5_color, bg6_color, bg7_color;
    logic [W-1:0] color, color_q;
    logic         bg_changed;

    exp_t       sb [$];
    logic [2:0] m_last;
    int         passed = 0;
    int         total  = 0;

    assign bg0_color = cols[0];
    assign bg1_color = cols[1];
    assign bg2_color = cols[2];
    assign bg3_color = cols[3];
    assign bg4_color = cols[4];
    assign bg5_color = cols[5];
    assign bg6_color = cols[6];
    assign bg7_color = cols[7];

    bg_mux #(.COLOR_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef BG_MUX_BLANK_EN
        .blank      (blank),
`endif
        .bg0_color  (bg0_color),
        .bg1_color  (bg1_color),
        .bg2_color  (bg2_color),
        .bg3_color  (bg3_color),
        .bg4_color  (bg4_color),
        .bg5_color  (bg5_color),
        .bg6_color  (bg6_color),
        .bg7_color  (bg7_color),
        .bg         (bg),
        .color      (color),
        .color_q    (color_q),
        .bg_changed (bg_changed)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d checks", passed, total);
        $fatal(1);
    end

    // Queue what the next edge should produce, then take that edge.
    task automatic step();
        exp_t e;
        e.cq  = cols[bg];
`ifdef BG_MUX_BLANK_EN
        if (blank) e.cq = '0;
`endif
        e.chg  = (bg != m_last);
        m_last = bg;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        m_last = 3'd0;
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        bg  = 3'd0;
        for (int i = 0; i < 8; i++) cols[i] = W'(i);
        #2;
        total++; if (color_q !== 3'd0) $display("FAIL reset_color_q got %0d want 0", color_q); else passed++;
        total++; if (bg_changed !== 1'b0) $display("FAIL reset_bg_changed got %0b want 0", bg_changed); else passed++;
        total++; if (color !== cols[0]) $display("FAIL reset_color got %0d want %0d", color, cols[0]); else passed++;
        release_reset();
        bg = 3'd0;
        step();
        e = sb.pop_front();
        total++; if (bg_changed !== 1'b0) $display("FAIL first_edge_bg0 got %0b want 0", bg_changed); else passed++;
        total++; if (color_q !== e.cq) $display("FAIL first_edge_cq got %0d want %0d", color_q, e.cq); else passed++;
    endtask

    task automatic test_select();
        exp_t e;
        logic [2:0] seq [9];
        for (int i = 0; i < 8; i++) cols[i] = W'(i);
        for (int i = 0; i < 8; i++) seq[i] = 3'(i);
        seq[8] = 3'd0;
        for (int i = 0; i < 9; i++) begin
            bg = seq[i];
            #1;
            total++; if (color !== W'(seq[i])) $display("FAIL select_comb bg=%0d got %0d want %0d", seq[i], color, seq[i]); else passed++;
            step();
            e = sb.pop_front();
            total++; if (color_q !== e.cq) $display("FAIL select_cq bg=%0d got %0d want %0d", seq[i], color_q, e.cq); else passed++;
            total++; if (bg_changed !== e.chg) $display("FAIL select_chg bg=%0d got %0b want %0b", seq[i], bg_changed, e.chg); else passed++;
        end
    endtask

    task automatic test_latency();
        exp_t e;
        bg = 3'd5; cols[5] = 3'd6;
        #1;
        total++; if (color_q === 3'd6) $display("FAIL latency_early got %0d want not 6 before edge", color_q); else passed++;
        step();
        e = sb.pop_front();
        total++; if (color_q !== 3'd6 || e.cq !== 3'd6) $display("FAIL latency_cq6 got %0d want 6", color_q); else passed++;
        bg = 3'd2; cols[2] = 3'd2;
        step();
        e = sb.pop_front();
        total++; if (color_q !== 3'd2 || e.cq !== 3'd2) $display("FAIL latency_cq2 got %0d want 2", color_q); else passed++;
    endtask

    task automatic test_changed();
        exp_t e;
        int   pulses = 0;
        bg = 3'd3;
        step();
        e = sb.pop_front();
        total++; if (bg_changed !== e.chg) $display("FAIL chg_enter got %0b want %0b", bg_changed, e.chg); else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            e = sb.pop_front();
            total++; if (bg_changed !== 1'b0) $display("FAIL chg_held%0d got %0b want 0", i, bg_changed); else passed++;
        end
        bg = 3'd4;
        for (int i = 0; i < 3; i++) begin
            step();
            e = sb.pop_front();
            if (bg_changed === 1'b1) pulses++;
            total++; if (bg_changed !== e.chg) $display("FAIL chg_after%0d got %0b want %0b", i, bg_changed, e.chg); else passed++;
        end
        total++; if (pulses !== 1) $display("FAIL chg_pulse_count got %0d want 1", pulses); else passed++;
    endtask

    task automatic test_nonselected();
        exp_t e;
        bg = 3'd1; cols[1] = 3'd5;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 8; j++) if (j != 1) cols[j] = W'($urandom_range(0, 7));
            #1;
            total++; if (color !== 3'd5) $display("FAIL nonsel_comb%0d got %0d want 5", i, color); else passed++;
            step();
            e = sb.pop_front();
            total++; if (color_q !== 3'd5 || e.cq !== 3'd5) $display("FAIL nonsel_cq%0d got %0d want 5", i, color_q); else passed++;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        cols[7] = 3'd7;
        bg = 3'd6;
        step();
        e = sb.pop_front();
        bg = 3'd7;
        step();
        e = sb.pop_front();
        total++; if (color_q !== 3'd7 || bg_changed !== 1'b1) $display("FAIL prereset got cq=%0d chg=%0b want cq=7 chg=1", color_q, bg_changed); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (color_q !== 3'd0) $display("FAIL async_cq got %0d want 0", color_q); else passed++;
        total++; if (bg_changed !== 1'b0) $display("FAIL async_chg got %0b want 0", bg_changed); else passed++;
        total++; if (color !== 3'd7) $display("FAIL async_color got %0d want 7", color); else passed++;
        release_reset();
        step();
        e = sb.pop_front();
        total++; if (bg_changed !== 1'b1) $display("FAIL release_bg7 got %0b want 1", bg_changed); else passed++;
        total++; if (color_q !== e.cq) $display("FAIL release_cq got %0d want %0d", color_q, e.cq); else passed++;
        step();
        e = sb.pop_front();
        total++; if (bg_changed !== 1'b0) $display("FAIL release_bg7_next got %0b want 0", bg_changed); else passed++;
    endtask

`ifdef BG_MUX_BLANK_EN
    task automatic test_blank();
        exp_t e;
        bg = 3'd7; cols[7] = 3'd7; blank = 1'b1;
        #1;
        total++; if (color !== 3'd0) $display("FAIL blank_comb got %0d want 0", color); else passed++;
        step();
        e = sb.pop_front();
        total++; if (color_q !== 3'd0) $display("FAIL blank_cq got %0d want 0", color_q); else passed++;
        blank = 1'b0;
        #1;
        total++; if (color !== 3'd7) $display("FAIL unblank_comb got %0d want 7", color); else passed++;
        step();
        e = sb.pop_front();
        total++; if (color_q !== 3'd7) $display("FAIL unblank_cq got %0d want 7", color_q); else passed++;
    endtask
`endif

    initial begin
`ifdef BG_MUX_BLANK_EN
        blank = 1'b0;
`endif
        test_reset();
        test_select();
        test_latency();
        test_changed();
        test_nonselected();
        test_async_reset();
`ifdef BG_MUX_BLANK_EN
        test_blank();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
